// File: rtl/dr32e_branch_resolve.sv
// dr32e_branch_resolve: execute-side checker for fetch-stage static branch predictions.
// Queues each prediction (taken flag + target) issued at fetch and pops the oldest entry when
// execute resolves that branch/jump. On a mispredict it emits a one-cycle registered redirect
// and discards every younger (wrong-path) prediction.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   pred_valid_i/ready_o/taken_i/target_i  prediction handshake from fetch
//   res_valid_i/taken_i/target_i/next_pc_i resolution of the oldest branch from execute
//   flush_i                            trap/exception flush, empties the queue
//   redirect_o, redirect_pc_o          mispredict redirect pulse and correct PC
//   empty_o, underflow_o               queue empty, resolve-while-empty error pulse
// Optional: define DR32E_BP_PERF_CNT_EN to add saturating branch_cnt_o / mispred_cnt_o.
module dr32e_branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        res_valid_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic [31:0] res_next_pc_i,
  input  logic        flush_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        empty_o,
  output logic        underflow_o
`ifdef DR32E_BP_PERF_CNT_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] taken_mem;
  logic [31:0] target_mem [DEPTH];
  logic full, push, pop, mispredict, underflow, rd_taken;
  logic [31:0] rd_target;
  assign empty_o = count == '0;
  assign full = count == CW'(DEPTH);
  assign push = pred_valid_i & pred_ready_o;
  assign pop = res_valid_i & ~empty_o & (state_q == RUN);
  assign rd_taken = taken_mem[rd_ptr];
  assign rd_target = target_mem[rd_ptr];
  assign mispredict = pop & ((rd_taken != res_taken_i) | (rd_taken & res_taken_i & (rd_target != res_target_i)));
  assign underflow = res_valid_i & empty_o & (state_q == RUN) & ~flush_i;
  always_ff @(posedge clk_i)
    if (!rst_ni) state_q <= RUN;
    else state_q <= state_d;
  always_comb state_d = (mispredict & ~flush_i) ? RECOVER : RUN;
  always_comb pred_ready_o = (state_q == RUN) & ~full;
  always_ff @(posedge clk_i)
    if (push) begin
      taken_mem[wr_ptr] <= pred_taken_i;
      target_mem[wr_ptr] <= pred_target_i;
    end
  // A mispredict or flush empties the queue, which also drops any same-cycle push.
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      redirect_o <= 1'b0;
      redirect_pc_o <= '0;
      underflow_o <= 1'b0;
    end else begin
      redirect_o <= mispredict & ~flush_i;
      underflow_o <= underflow;
      if (mispredict & ~flush_i) redirect_pc_o <= res_taken_i ? res_target_i : res_next_pc_i;
      if (flush_i | mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
`ifdef DR32E_BP_PERF_CNT_EN
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      branch_cnt_o <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (pop & ~&branch_cnt_o) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (mispredict & ~&mispred_cnt_o) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
`endif
endmodule
